// File: rtl/buf_pingpong_if.sv
// Bus bundle for the ping-pong operand feed buffer: configuration, write
// port, read port and status flags. The loader/bench side uses master, the
// buffer uses slave.
interface buf_pingpong_if #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_nDATA  = 1024,
  parameter int REP_WIDTH  = 8
);
  localparam int ADDR_WIDTH = $clog2(MAX_nDATA);

  logic                  clear;
  logic [ADDR_WIDTH:0]   config_size;
  logic [REP_WIDTH-1:0]  config_rep;
  logic                  we;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_ready;
  logic                  re;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic                  reachend;
  logic                  bank_done;
  logic                  full;
  logic                  empty;

  modport master (
    output clear, config_size, config_rep, we, data_in, re,
    input  wr_ready, data_out, out_valid, reachend, bank_done, full, empty
  );

  modport slave (
    input  clear, config_size, config_rep, we, data_in, re,
    output wr_ready, data_out, out_valid, reachend, bank_done, full, empty
  );
endinterface

// File: rtl/buf_pingpong.sv
// Two-bank operand feed buffer. The loader fills one bank while the compute
// side replays the other bank circularly for a programmed number of passes.
//
// Per-bank state:
//   state      | meaning
//   ST_EMPTY   | free, next write starts a new data set (latches size/rep)
//   ST_FILLING | partially written, still owned by the write side
//   ST_LOADED  | complete, not yet read
//   ST_READING | being replayed; returns to ST_EMPTY when released
module buf_pingpong #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_nDATA  = 1024,
  parameter int REP_WIDTH  = 8
) (
  input logic           clk,
  input logic           rst,
  buf_pingpong_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(MAX_nDATA);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_LOADED  = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  localparam logic [ADDR_WIDTH:0]   MAX_SIZE = (ADDR_WIDTH+1)'(MAX_nDATA);
  localparam logic [ADDR_WIDTH:0]   SIZE_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0]  REP_ONE  = REP_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [0:2*MAX_nDATA-1];

  logic [1:0]            r_state [0:1];
  logic [ADDR_WIDTH:0]   r_size  [0:1];
  logic [REP_WIDTH-1:0]  r_rep   [0:1];
  logic                  r_wbank;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic                  r_rbank;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [REP_WIDTH-1:0]  r_pass;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_out_valid;
  logic                  r_reachend;
  logic                  r_bank_done;

  logic [1:0]            w_state_nxt [0:1];
  logic [ADDR_WIDTH:0]   w_cfg_size;
  logic [ADDR_WIDTH:0]   w_wsize;
  logic                  w_wbank_free;
  logic                  w_wr_ready;
  logic                  w_wr_acc;
  logic                  w_wlast;
  logic                  w_rd_avail;
  logic                  w_rd_acc;
  logic                  w_rlast;
  logic                  w_rep_done;
  logic                  w_other_loaded;
  logic                  w_release;

  // Zero or oversize requests mean a full bank.
  assign w_cfg_size = (bus.config_size == '0 || bus.config_size > MAX_SIZE) ?
                      MAX_SIZE : bus.config_size;

  assign w_wbank_free = (r_state[r_wbank] == ST_EMPTY);
  assign w_wr_ready   = w_wbank_free || (r_state[r_wbank] == ST_FILLING);
  assign w_wr_acc     = bus.we && w_wr_ready && !bus.clear;
  // The first write of a set must see the size being latched, not the stale one.
  assign w_wsize      = w_wbank_free ? w_cfg_size : r_size[r_wbank];
  assign w_wlast      = ({1'b0, r_wptr} == (w_wsize - SIZE_ONE));

  assign w_rd_avail     = (r_state[r_rbank] == ST_LOADED) || (r_state[r_rbank] == ST_READING);
  assign w_rd_acc       = bus.re && w_rd_avail && !bus.clear;
  assign w_rlast        = ({1'b0, r_rptr} == (r_size[r_rbank] - SIZE_ONE));
  assign w_rep_done     = (r_rep[r_rbank] != '0) && (r_pass == (r_rep[r_rbank] - REP_ONE));
  assign w_other_loaded = (r_state[~r_rbank] == ST_LOADED);
  assign w_release      = w_rlast &&
                          (w_rep_done || ((r_rep[r_rbank] == '0) && w_other_loaded));

  // Write and read never touch the same bank in one cycle, so both updates apply.
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    if (w_wr_acc) w_state_nxt[r_wbank] = w_wlast ? ST_LOADED : ST_FILLING;
    if (w_rd_acc) w_state_nxt[r_rbank] = w_release ? ST_EMPTY : ST_READING;
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[{r_wbank, r_wptr}] <= bus.data_in;
  end

  // Bank states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
    end else if (bus.clear) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  // Write pointer, bank select and per-bank size/rep latched on the first write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wbank   <= 1'b0;
      r_wptr    <= '0;
      r_size[0] <= '0;
      r_size[1] <= '0;
      r_rep[0]  <= '0;
      r_rep[1]  <= '0;
    end else if (bus.clear) begin
      r_wbank   <= 1'b0;
      r_wptr    <= '0;
      r_size[0] <= '0;
      r_size[1] <= '0;
      r_rep[0]  <= '0;
      r_rep[1]  <= '0;
    end else if (w_wr_acc) begin
      if (w_wbank_free) begin
        r_size[r_wbank] <= w_cfg_size;
        r_rep[r_wbank]  <= bus.config_rep;
      end
      if (w_wlast) begin
        r_wptr  <= '0;
        r_wbank <= ~r_wbank;
      end else begin
        r_wptr <= r_wptr + PTR_ONE;
      end
    end
  end

  // Read pointer, pass counter and the registered output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rbank     <= 1'b0;
      r_rptr      <= '0;
      r_pass      <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_reachend  <= 1'b0;
      r_bank_done <= 1'b0;
    end else if (bus.clear) begin
      r_rbank     <= 1'b0;
      r_rptr      <= '0;
      r_pass      <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_reachend  <= 1'b0;
      r_bank_done <= 1'b0;
    end else begin
      r_out_valid <= w_rd_acc;
      r_reachend  <= w_rd_acc && w_rlast;
      r_bank_done <= w_rd_acc && w_release;
      if (w_rd_acc) begin
        r_data_out <= r_mem[{r_rbank, r_rptr}];
        if (w_rlast) begin
          r_rptr <= '0;
          if (w_release) begin
            r_pass  <= '0;
            r_rbank <= ~r_rbank;
          end else begin
            r_pass <= r_pass + REP_ONE;
          end
        end else begin
          r_rptr <= r_rptr + PTR_ONE;
        end
      end
    end
  end

  assign bus.wr_ready  = w_wr_ready;
  assign bus.full      = !w_wr_ready;
  assign bus.empty     = !((r_state[0] == ST_LOADED) || (r_state[0] == ST_READING) ||
                           (r_state[1] == ST_LOADED) || (r_state[1] == ST_READING));
  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;
  assign bus.reachend  = r_reachend;
  assign bus.bank_done = r_bank_done;
endmodule

// File: doc/buf_pingpong.md
Name: buf_pingpong

Overview:
- Parametrised successor to the single-bank operand feed buffer.
- Two-bank (ping-pong) store. The producer fills one bank while the consumer replays the other bank circularly for a programmable number of passes.
- Removes the fill/drain stall between data sets.
- Sits between the DMA/loader and a compute array as the operand feeder.

Parameters:
- DATA_WIDTH, 16: word width.
- MAX_nDATA, 1024: maximum words per bank (power of two). ADDR_WIDTH = clog2(MAX_nDATA).
- REP_WIDTH, 8: width of the pass-count configuration.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-low.
- clear, in, 1: synchronous soft clear.
- config_size, in, ADDR_WIDTH+1: words per data set.
- config_rep, in, REP_WIDTH: passes per bank. 0 = loop until the next bank is loaded.
- we, in, 1: write strobe.
- data_in, in, DATA_WIDTH: write data.
- wr_ready, out, 1: write bank can accept data.
- re, in, 1: read strobe.
- data_out, out, DATA_WIDTH: read data, registered.
- out_valid, out, 1: data_out holds a word read in the previous cycle.
- reachend, out, 1: pulse aligned with the last word of each pass.
- bank_done, out, 1: pulse aligned with the last word of the final pass of a bank.
- full, out, 1: both banks occupied (equals ~wr_ready).
- empty, out, 1: no bank readable.

Behaviour:
- Storage: 2*MAX_nDATA words, simple dual-port (one write port, one read port), addressed as {bank, ptr}. Memory contents are not reset.
- Per-bank state: EMPTY, FILLING, LOADED, READING. Per-bank registers: size and rep, latched at the first write into the bank.
- Size rule: config_size of 0 or greater than MAX_nDATA is clamped to MAX_nDATA.
- Write side:
  - wbank and wptr start at 0.
  - wr_ready = 1 when state[wbank] is EMPTY or FILLING.
  - A write is accepted when we & wr_ready. Writes with wr_ready = 0 are dropped; there is no side effect.
  - An accepted write stores data at {wbank, wptr}, sets the bank to FILLING, and increments wptr.
  - When wptr reaches size-1 and that write is accepted: bank goes to LOADED, wptr goes to 0, wbank toggles.
- Read side:
  - rbank, rptr and pass count all start at 0.
  - A read is accepted when re and state[rbank] is LOADED or READING. Otherwise re is ignored.
  - An accepted read sets the bank to READING. data_out = mem[{rbank, rptr}] one cycle later with out_valid = 1. Otherwise out_valid = 0 and data_out holds its value.
  - rptr increments and wraps from size-1 to 0. At the wrap, pass count increments and reachend asserts in the next cycle, aligned with out_valid.
- End of pass: the bank is released when either condition holds:
  - rep != 0 and pass count == rep-1; or
  - rep == 0 and the other bank is LOADED.
- On release: bank goes to EMPTY, rbank toggles, pass count goes to 0, and bank_done asserts with reachend.
- rep == 0 with no other bank loaded: replay continues indefinitely.
- Single-word sets (size = 1): every accepted read is a pass end.
- Simultaneous events:
  - A write completing bank A and a read releasing bank B in the same cycle both take effect.
  - A write to an EMPTY bank in the same cycle it is released is accepted in the following cycle. wr_ready is computed from registered state.
- Flags:
  - empty = 1 iff no bank is LOADED or READING.
  - full = 1 iff state[wbank] is LOADED or READING.
- Reset (rst = 0, asynchronous):
  - Banks go to EMPTY; all pointers and counters go to 0.
  - data_out = 0, out_valid = 0, reachend = 0, bank_done = 0, wr_ready = 1, full = 0, empty = 1.
  - Any in-flight read result is discarded.
- clear: produces the same register values as reset, synchronously, and has priority over we/re in that cycle.

Test Plan:
- Reset, size = 4, rep = 2, write 0xA0..0xA3, then re held 8 cycles:
  - data_out = A0..A3, A0..A3, with out_valid following re by 1 cycle.
  - reachend on the 4th and 8th words; bank_done on the 8th only; empty = 1 afterwards.
- Ping-pong: bank0 = {1,2,3}, then bank1 = {7,8,9} written while bank0 is read with rep = 1:
  - Read stream 1,2,3,7,8,9 with no gap under continuous re.
  - full = 1 only while both banks are occupied; writes during full are dropped.
- rep = 0: bank0 = {5,6}, re continuous:
  - Output 5,6,5,6,... until bank1 = {E} is loaded.
  - The switch occurs only at a pass boundary, with bank_done on that final 6, then E,E,...
- Simultaneous completion: the last write of bank1 lands in the same cycle bank0 is released → bank1 is readable next cycle, and wr_ready rises for bank0 next cycle.
- clear asserted mid-fill and mid-read:
  - Next cycle: empty = 1, full = 0, out_valid = 0.
  - A subsequent fill of size 2 reads back correctly from bank0, ptr 0.
- Asynchronous rst pulse between clock edges during a read → outputs take reset values immediately, with no out_valid pulse afterwards. Clamp check: config_size = 0 with MAX_nDATA = 8 → the bank loads after 8 writes.
